// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and instruction fetch stage
module fetch_pc_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_en,
    input  logic              br_en,
    input  logic              jmp_en,
    input  logic              pc_sel,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [4:0]        flags,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic [15:0]       ir,
    output logic              instr_valid,
    output logic              busy,
    output logic              taken
);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] disp;
    logic              taken_d;
    logic              cond_ok;

    // flags = {N,Z,F,L,C}
    function automatic logic cond_met(input logic [3:0] c, input logic [4:0] f);
        logic n, z, fl, l, cy;
        n  = f[4];
        z  = f[3];
        fl = f[2];
        l  = f[1];
        cy = f[0];
        case (c)
            4'h0: cond_met = z;
            4'h1: cond_met = !z;
            4'h2: cond_met = cy;
            4'h3: cond_met = !cy;
            4'h4: cond_met = l;
            4'h5: cond_met = !l;
            4'h6: cond_met = n;
            4'h7: cond_met = !n;
            4'h8: cond_met = fl;
            4'h9: cond_met = !fl;
            4'hA: cond_met = !l && !z;
            4'hB: cond_met = l || z;
            4'hC: cond_met = !n && !z;
            4'hD: cond_met = n || z;
            4'hE: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    assign cond_ok   = cond_met(ir[11:8], flags);
    assign disp      = {{(ADDR_W-8){ir[7]}}, ir[7:0]};
    assign link_addr = pc + ONE;
    assign busy      = (state_q != IDLE);
    // While fetching, the address always comes from the PC
    assign mem_addr  = (busy || pc_sel) ? pc : reg_addr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_req) state_d = ADDR;
            ADDR:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc;
        taken_d = 1'b0;
        if (!busy) begin
            if (jmp_en) begin
                taken_d = cond_ok;
                pc_d    = cond_ok ? jmp_target : pc + ONE;
            end else if (br_en) begin
                taken_d = cond_ok;
                pc_d    = cond_ok ? pc + disp : pc + ONE;
            end else if (pc_en) begin
                pc_d = pc + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_valid <= 1'b0;
            taken       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            taken       <= taken_d;
            instr_valid <= (state_q == CAPT);
            if (state_q == CAPT) ir <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, pc_en, br_en, jmp_en, pc_sel;
    logic [15:0] reg_addr, jmp_target;
    logic [4:0]  flags;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, pc, link_addr, ir;
    logic        instr_valid, busy, taken;

    logic [15:0] mem [0:255];
    logic [15:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_en(pc_en),
        .br_en(br_en), .jmp_en(jmp_en), .pc_sel(pc_sel), .reg_addr(reg_addr),
        .jmp_target(jmp_target), .flags(flags), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .pc(pc), .link_addr(link_addr), .ir(ir),
        .instr_valid(instr_valid), .busy(busy), .taken(taken)
    );

    // Memory returns data one cycle after the address is presented
    always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every instr_valid must match the oldest pending fetch
    always @(posedge clk) begin
        #1;
        if (instr_valid) begin
            if (sb.size() == 0) check("unexpected_instr_valid", 1, 0);
            else check("sb_ir", ir, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] exp_pc);
        fetch_req = 1'b1;
        sb.push_back(mem[exp_pc[7:0]]);
        step();
        fetch_req = 1'b0;
        check("addr_busy", busy, 1);
        check("addr_mem_addr", mem_addr, exp_pc);
        step();
        check("capt_busy", busy, 1);
        check("capt_iv", instr_valid, 0);
        step();
        check("done_busy", busy, 0);
        check("done_iv", instr_valid, 1);
        step();
        check("iv_pulse", instr_valid, 0);
        check("fetch_pc_hold", pc, exp_pc);
    endtask

    task automatic pc_op(input string tag, input logic j, input logic b, input logic inc,
                         input logic [15:0] tgt, input logic [4:0] fl,
                         input logic [15:0] exp_pc, input logic exp_taken);
        jmp_en = j; br_en = b; pc_en = inc; jmp_target = tgt; flags = fl;
        step();
        jmp_en = 1'b0; br_en = 1'b0; pc_en = 1'b0;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_taken"}, taken, exp_taken);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0153;
        mem[8'h01] = 16'h0C80;
        mem[8'h10] = 16'h40FC;
        mem[8'h20] = 16'h0E05;
        reset = 1'b0; fetch_req = 0; pc_en = 0; br_en = 0; jmp_en = 0;
        pc_sel = 1'b1; reg_addr = 16'h0; jmp_target = 16'h0; flags = 5'b0;
        step(); step();
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_iv", instr_valid, 0);
        check("rst_taken", taken, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step();

        do_fetch(16'h0000);
        check("ir_0153", ir, 16'h0153);

        // ir cond NE with Z=0 -> jump taken
        pc_op("jmp_ne", 1, 0, 0, 16'h0010, 5'b00000, 16'h0010, 1);
        step();
        check("taken_clear", taken, 0);
        check("idle_hold_pc", pc, 16'h0010);
        do_fetch(16'h0010);
        pc_op("beq_z1", 0, 1, 0, 16'h0, 5'b01000, 16'h000C, 1);
        pc_op("jeq_back", 1, 0, 0, 16'h0010, 5'b01000, 16'h0010, 1);
        pc_op("beq_z0", 0, 1, 0, 16'h0, 5'b00000, 16'h0011, 0);
        pc_op("jeq_20", 1, 0, 0, 16'h0020, 5'b01000, 16'h0020, 1);
        do_fetch(16'h0020);
        check("link_addr", link_addr, 16'h0021);
        pc_op("jmp_over_br", 1, 1, 1, 16'h1234, 5'b00000, 16'h1234, 1);
        pc_op("jmp_ffff", 1, 0, 0, 16'hFFFF, 5'b00000, 16'hFFFF, 1);
        pc_op("inc_wrap", 0, 0, 1, 16'h0, 5'b00000, 16'h0000, 0);
        pc_op("inc_1", 0, 0, 1, 16'h0, 5'b00000, 16'h0001, 0);
        do_fetch(16'h0001);
        pc_op("blt", 0, 1, 0, 16'h0, 5'b00000, 16'hFF81, 1);
        pc_op("jlt_not", 1, 0, 0, 16'h4444, 5'b10000, 16'hFF82, 0);
        pc_op("jlt_0", 1, 0, 0, 16'h0000, 5'b00000, 16'h0000, 1);

        // fetch with simultaneous increment; updates while busy are ignored
        fetch_req = 1'b1; pc_en = 1'b1;
        sb.push_back(mem[1]);
        step();
        fetch_req = 1'b0; pc_sel = 1'b0; reg_addr = 16'h0300;
        #1;
        check("fetch_upd_addr", mem_addr, 16'h0001);
        step();
        check("busy_pc_hold1", pc, 16'h0001);
        step();
        check("busy_pc_hold2", pc, 16'h0001);
        check("upd_fetch_iv", instr_valid, 1);
        pc_en = 1'b0;
        #1;
        check("reg_addr_sel", mem_addr, 16'h0300);
        pc_sel = 1'b1;
        step();

        // asynchronous reset in the middle of CAPT
        fetch_req = 1'b1;
        sb.push_back(mem[1]);
        step();
        fetch_req = 1'b0;
        step();
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_ir", ir, 16'h0000);
        check("arst_busy", busy, 0);
        check("arst_pc", pc, 16'h0000);
        check("arst_iv", instr_valid, 0);
        sb.delete();
        step();
        check("arst_no_iv", instr_valid, 0);
        reset = 1'b1;
        step();
        check("post_rst_iv", instr_valid, 0);
        check("post_rst_pc", pc, 16'h0000);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
